// File: rtl/game_state_ctrl.sv
// Frame-paced game state controller: death freeze, blinking game-over overlay,
// and debounced restart key-hold producing a one-cycle restart pulse.
module game_state_ctrl #(
  parameter int unsigned DYING_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       hp_zero,
  input  logic       start_key,
  output logic       Game_Over_On,
  output logic       Game_Freeze,
  output logic       Game_Restart,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    DYING   = 2'd1,
    OVER    = 2'd2,
    RESTART = 2'd3
  } state_e;

  localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  logic       frame_meta_q, frame_sync_q, frame_prev_q;
  logic       tick;
  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       armed_q, armed_d;
  logic       grace_q, grace_d;
  logic       over_on_q, freeze_q, restart_q;

  // frame_clk is asynchronous: two flops for metastability, a third for edge detect.
  assign tick = frame_sync_q & ~frame_prev_q;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    blink_on_d  = blink_on_q;
    armed_d     = armed_q;
    grace_d     = grace_q;

    unique case (state_q)
      PLAY: begin
        if (tick) grace_d = 1'b0;
        if (!grace_q && hp_zero) begin
          state_d     = DYING;
          frame_cnt_d = '0;
        end
      end

      DYING: begin
        if (tick) begin
          if (frame_cnt_q == DYING_LAST) begin
            state_d     = OVER;
            frame_cnt_d = '0;
            blink_on_d  = 1'b1;
            armed_d     = 1'b0;
            hold_cnt_d  = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      OVER: begin
        if (tick) begin
          if (frame_cnt_q == BLINK_LAST) begin
            blink_on_d  = ~blink_on_q;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        // A released key both arms the hold and breaks any hold in progress,
        // even on a tick cycle.
        if (!start_key) begin
          armed_d    = 1'b1;
          hold_cnt_d = '0;
        end else if (armed_q && tick) begin
          if (hold_cnt_q == HOLD_LAST) state_d = RESTART;
          else                         hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      RESTART: begin
        state_d     = PLAY;
        grace_d     = 1'b1;
        frame_cnt_d = '0;
        hold_cnt_d  = '0;
        blink_on_d  = 1'b0;
        armed_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_meta_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      state_q      <= PLAY;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      blink_on_q   <= 1'b0;
      armed_q      <= 1'b0;
      grace_q      <= 1'b1;
      over_on_q    <= 1'b0;
      freeze_q     <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      frame_meta_q <= frame_clk;
      frame_sync_q <= frame_meta_q;
      frame_prev_q <= frame_sync_q;
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_on_q   <= blink_on_d;
      armed_q      <= armed_d;
      grace_q      <= grace_d;
      over_on_q    <= (state_d == OVER) && blink_on_d;
      freeze_q     <= (state_d != PLAY);
      restart_q    <= (state_d == RESTART);
    end
  end

  assign Game_Over_On = over_on_q;
  assign Game_Freeze  = freeze_q;
  assign Game_Restart = restart_q;
  assign State        = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a tick-counting model.
module tb_game_state_ctrl;

  localparam int DF = 4;
  localparam int BF = 2;
  localparam int HF = 3;

  localparam int M_PLAY    = 0;
  localparam int M_DYING   = 1;
  localparam int M_OVER    = 2;
  localparam int M_RESTART = 3;

  logic       Clk       = 1'b0;
  logic       Reset     = 1'b0;
  logic       frame_clk = 1'b0;
  logic       hp_zero   = 1'b0;
  logic       start_key = 1'b0;
  logic       Game_Over_On;
  logic       Game_Freeze;
  logic       Game_Restart;
  logic [1:0] State;

  int checks      = 0;
  int failures    = 0;
  int restart_cnt = 0;

  // Model: mode plus plain counts of ticks spent in the current phase.
  int m_mode;
  bit m_grace;
  int m_dying_ticks;
  int m_over_ticks;
  bit m_armed;
  int m_hold;
  bit h1, h2, h3;  // raw frame samples from 1, 2 and 3 edges ago

  game_state_ctrl #(
    .DYING_FRAMES(DF),
    .BLINK_FRAMES(BF),
    .HOLD_FRAMES (HF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .hp_zero     (hp_zero),
    .start_key   (start_key),
    .Game_Over_On(Game_Over_On),
    .Game_Freeze (Game_Freeze),
    .Game_Restart(Game_Restart),
    .State       (State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode        = M_PLAY;
    m_grace       = 1'b1;
    m_dying_ticks = 0;
    m_over_ticks  = 0;
    m_armed       = 1'b0;
    m_hold        = 0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_step(input bit fr, input bit hp, input bit sk);
    bit tk;
    // A frame rise seen at edge k is acted on at edge k+2.
    tk = h2 && !h3;
    h3 = h2; h2 = h1; h1 = fr;
    if (m_mode == M_PLAY) begin
      if (!m_grace && hp) begin
        m_mode        = M_DYING;
        m_dying_ticks = 0;
      end
      if (tk) m_grace = 1'b0;
    end else if (m_mode == M_DYING) begin
      if (tk) begin
        m_dying_ticks++;
        if (m_dying_ticks == DF) begin
          m_mode       = M_OVER;
          m_over_ticks = 0;
          m_armed      = 1'b0;
          m_hold       = 0;
        end
      end
    end else if (m_mode == M_OVER) begin
      if (tk) m_over_ticks++;
      if (!sk) begin
        m_armed = 1'b1;
        m_hold  = 0;
      end else if (m_armed && tk) begin
        m_hold++;
        if (m_hold == HF) m_mode = M_RESTART;
      end
    end else begin
      m_mode  = M_PLAY;
      m_grace = 1'b1;
    end
  endtask

  function automatic bit exp_over_on();
    return (m_mode == M_OVER) && (((m_over_ticks / BF) % 2) == 0);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) model_reset();
      else       model_step(frame_clk, hp_zero, start_key);
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (Game_Restart === 1'b1) restart_cnt++;
        check("model_state",   State,        m_mode);
        check("model_freeze",  Game_Freeze,  m_mode != M_PLAY);
        check("model_restart", Game_Restart, m_mode == M_RESTART);
        check("model_over_on", Game_Over_On, exp_over_on());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_tick();
    frame_clk = 1'b1; cyc(2);
    frame_clk = 1'b0; cyc(2);
  endtask

  // Release start_key for exactly the cycle whose edge consumes the tick.
  task automatic do_tick_drop();
    frame_clk = 1'b1; cyc(2);
    start_key = 1'b0; cyc(1);
    start_key = 1'b1; frame_clk = 1'b0; cyc(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_over_on"}, Game_Over_On, 0);
    check({tag, "_freeze"},  Game_Freeze,  0);
    check({tag, "_restart"}, Game_Restart, 0);
    check({tag, "_state"},   State,        0);
  endtask

  int r0;
  int blink_exp [5] = '{1, 0, 0, 1, 1};

  initial begin
    #1 Reset = 1'b1;
    cyc(2);
    #2 Reset = 1'b0;
    cyc(1);
    check_all_zero("after_reset");

    // Death path and blink cadence.
    do_tick();
    check("grace_tick_state", State, 0);
    hp_zero = 1'b1; cyc(1);
    check("death_freeze", Game_Freeze, 1);
    check("death_state",  State,       1);
    hp_zero = 1'b0;
    repeat (DF - 1) do_tick();
    check("dying_state",   State,        1);
    check("dying_over_on", Game_Over_On, 0);
    do_tick();
    check("over_state",   State,        2);
    check("over_over_on", Game_Over_On, 1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check($sformatf("blink_%0d", i), Game_Over_On, blink_exp[i]);
    end

    // Async reset in OVER with the overlay on, hp_zero high.
    r0 = restart_cnt;
    hp_zero = 1'b1;
    #2 Reset = 1'b1;
    #1 check_all_zero("async_reset");
    cyc(1);
    #2 Reset = 1'b0;
    cyc(8);
    check("idle_grace_state",  State,       0);
    check("idle_grace_freeze", Game_Freeze, 0);
    check("async_no_restart",  restart_cnt - r0, 0);

    // Key held from DYING into OVER must be released before it counts.
    start_key = 1'b1;
    do_tick();
    check("held_dying_state", State, 1);
    hp_zero = 1'b0;
    repeat (DF) do_tick();
    r0 = restart_cnt;
    repeat (10) do_tick();
    check("held_still_over",  State, 2);
    check("held_no_restart",  restart_cnt - r0, 0);
    start_key = 1'b0; cyc(1);
    start_key = 1'b1;
    repeat (HF) do_tick();
    check("held_one_restart", restart_cnt - r0, 1);
    check("held_back_play",   State, 0);

    // Broken hold, key drop coinciding with a tick, then a full hold.
    hp_zero = 1'b1; start_key = 1'b0;
    do_tick();
    hp_zero = 1'b0;
    repeat (DF) do_tick();
    check("broken_over_state", State, 2);
    r0 = restart_cnt;
    start_key = 1'b1;
    repeat (2) do_tick();
    start_key = 1'b0; cyc(1);
    start_key = 1'b1;
    repeat (2) do_tick();
    do_tick_drop();
    repeat (2) do_tick();
    check("broken_no_restart", restart_cnt - r0, 0);
    check("broken_still_over", State, 2);
    hp_zero = 1'b1;
    do_tick();
    check("broken_restart", restart_cnt - r0, 1);
    cyc(5);
    check("post_restart_grace", State, 0);
    do_tick();
    check("post_grace_dying", State, 1);
    hp_zero = 1'b0; start_key = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0)  frame_clk = ~frame_clk;
      if ($urandom_range(0, 23) == 0) start_key = ~start_key;
      hp_zero = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #3 Reset = 1'b1;
        #1 check_all_zero("rand_reset");
        cyc(1);
        #2 Reset = 1'b0;
      end
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
